// File: rtl/frac_clk_div_if.sv
// Control/status bundle for frac_clk_div: run enable, ratio request and frame status.
// cfg_load is a one-cycle pulse with no back-pressure; cfg_busy stays high until the
// captured ratio goes live at a frame start, and a later pulse simply replaces it.
interface frac_clk_div_if #(
    parameter int CNT_W = 6
) ();
    logic             en;
    logic [CNT_W-1:0] div_int;
    logic             div_half;
    logic             cfg_load;
    logic             cfg_busy;
    logic             frame_tick;

    modport master (
        output en, div_int, div_half, cfg_load,
        input  cfg_busy, frame_tick
    );

    modport slave (
        input  en, div_int, div_half, cfg_load,
        output cfg_busy, frame_tick
    );
endinterface

// File: rtl/frac_clk_div.sv
// Divide clk by N or N+0.5 using a posedge phase flop and a negedge phase flop, XOR-combined.
// Define FRAC_DIV_DEBUG_EN to expose dbg_cnt / dbg_pos / dbg_neg.
module frac_clk_div #(
    parameter int CNT_W    = 6,
    parameter int DEF_INT  = 4,
    parameter int DEF_HALF = 1
) (
    input  logic           clk,
    input  logic           rst,
    frac_clk_div_if.slave  bus,
    output logic           clk_o
`ifdef FRAC_DIV_DEBUG_EN
    ,
    output logic [CNT_W:0] dbg_cnt,
    output logic           dbg_pos,
    output logic           dbg_neg
`endif
);
    localparam int KW = CNT_W + 2;
    localparam logic [CNT_W-1:0] RST_INT  = (DEF_INT < 2) ? CNT_W'(2) : CNT_W'(DEF_INT);
    localparam logic             RST_HALF = (DEF_HALF != 0);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] act_int, pend_int, cap_int, use_int;
    logic             act_half, pend_half, use_half;
    logic             busy;
    logic [CNT_W:0]   cnt, cnt_nxt, last_cnt;
    logic             pos_q, neg_q, b_q, tick_q;
    logic             frame_end, frame_start, want_a, want_b;

    // Output level for half-period k of a frame of ratio n + 0.5h.
    function automatic logic is_high(input logic [KW-1:0] k, input logic [CNT_W-1:0] n,
                                     input logic h);
        logic [KW-1:0] nn, lo2, hi2;
        nn  = KW'(n);
        lo2 = (nn << 1) + KW'(1);
        hi2 = (nn << 1) + nn + KW'(1);
        return (k < nn) || (h && (k >= lo2) && (k < hi2));
    endfunction

    assign cap_int     = (bus.div_int < CNT_W'(2)) ? CNT_W'(2) : bus.div_int;
    assign last_cnt    = act_half ? {act_int, 1'b0} : ({1'b0, act_int} - (CNT_W+1)'(1));
    assign frame_end   = (cnt == last_cnt);
    assign frame_start = bus.en && ((state == IDLE) || frame_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en) state_nxt = RUN;
            RUN:     if (frame_end && !bus.en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Desired level of both halves of the coming clk cycle; the new ratio takes over at frame start.
    always_comb begin
        cnt_nxt  = '0;
        use_int  = act_int;
        use_half = act_half;
        want_a   = 1'b0;
        want_b   = 1'b0;
        if (frame_start) begin
            use_int  = pend_int;
            use_half = pend_half;
            want_a   = is_high({cnt_nxt, 1'b0}, use_int, use_half);
            want_b   = is_high({cnt_nxt, 1'b1}, use_int, use_half);
        end else if (state == RUN) begin
            cnt_nxt  = cnt + (CNT_W+1)'(1);
            want_a   = is_high({cnt_nxt, 1'b0}, use_int, use_half);
            want_b   = is_high({cnt_nxt, 1'b1}, use_int, use_half);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            pos_q     <= 1'b0;
            b_q       <= 1'b0;
            tick_q    <= 1'b0;
            act_int   <= RST_INT;
            act_half  <= RST_HALF;
            pend_int  <= RST_INT;
            pend_half <= RST_HALF;
            busy      <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            pos_q  <= want_a ^ neg_q;
            b_q    <= want_b;
            tick_q <= frame_start;
            if (frame_start) begin
                act_int  <= pend_int;
                act_half <= pend_half;
            end
            if (bus.cfg_load) begin
                pend_int  <= cap_int;
                pend_half <= bus.div_half;
                busy      <= 1'b1;
            end else if (frame_start) begin
                busy <= 1'b0;
            end
        end
    end

    // Flipping neg_q at the falling edge moves clk_o to the second-half level b_q.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= b_q ^ pos_q;
    end

    assign clk_o          = pos_q ^ neg_q;
    assign bus.cfg_busy   = busy;
    assign bus.frame_tick = tick_q;

`ifdef FRAC_DIV_DEBUG_EN
    assign dbg_cnt = cnt;
    assign dbg_pos = pos_q;
    assign dbg_neg = neg_q;
`endif
endmodule
